// File: rtl/vga_pkg.sv
// Shared VGA constants and types: 640x480@60 timing defaults,
// totals, coordinate and colour widths used by timing and renderers.
package vga_pkg;

    localparam int COORD_W = 11;
    localparam int COLOR_W = 5;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_CLK_DIV   = 4;

    localparam int VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/tick_divider.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and strobes p_tick on the last.
// Ports: clk, rst_n (async, active-low), p_tick (one clk wide).
module tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync and blanking decode.
// Ports: clk, rst_n, p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t V_VLST = coord_t'(V_DISPLAY - 1);
    localparam coord_t H_SS   = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SE   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t V_SS   = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SE   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    coord_t x_nxt;
    coord_t y_nxt;

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (p_tick)
    );

    always_comb begin
        x_nxt = pixel_x;
        y_nxt = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                x_nxt = '0;
                if (pixel_y == V_LAST) begin
                    y_nxt = '0;
                end else begin
                    y_nxt = pixel_y + coord_t'(1);
                end
            end else begin
                x_nxt = pixel_x + coord_t'(1);
            end
        end
    end

    // Sync/blank flops decode the next counter value so they
    // line up with pixel_x/pixel_y in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x  <= '0;
            pixel_y  <= '0;
            video_on <= 1'b1;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
        end else begin
            pixel_x  <= x_nxt;
            pixel_y  <= y_nxt;
            video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync    <= !((x_nxt >= H_SS) && (x_nxt < H_SE));
            vsync    <= !((y_nxt >= V_SS) && (y_nxt < V_SE));
        end
    end

    assign frame_tick = p_tick
                     && (pixel_x == H_LAST)
                     && (pixel_y == V_VLST);

endmodule
